mem_port_arbiter: RTL

//  Shares one unified memory port between the fetch stage (I, read-only) and the memory stage (D, load/store).

---
 rtl/mem_port_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the fetch stage (I, read-only) and
//   the memory stage (D, load/store). One access is in flight at a time and is
//   sequenced IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// Ports
//   clock, reset_n                      clock, async active-low reset
//   i_req/i_addr/i_size -> i_ack/i_rdata fetch read channel
//   d_req/d_we/d_addr/d_wdata/d_size -> d_ack/d_rdata   data channel
//   i_stall, d_stall                    pending-and-not-done hints
//   m_enable/m_rw/m_address/m_data_in/m_access_size, m_busy/m_data_out
//                                       memory handshake
//   stat_i_grants/stat_d_grants/stat_conflicts   optional counters
//
// Build option
//   MEM_ARB_STATS_EN : enables the three 32-bit wrapping stat counters;
//                      when undefined the stat_* ports read 0.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_size,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              i_stall,
  output logic              d_stall,
  output logic              m_enable,
  output logic              m_rw,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_data_in,
  output logic [1:0]        m_access_size,
  input  logic              m_busy,
  input  logic [DATA_W-1:0] m_data_out,
  output logic [31:0]       stat_i_grants,
  output logic [31:0]       stat_d_grants,
  output logic [31:0]       stat_conflicts
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic              owner_i_q, owner_i_d;   // 1: access belongs to I
  logic [SW-1:0]     starve_q, starve_d;
  logic              m_enable_q, m_enable_d;
  logic              m_rw_q, m_rw_d;
  logic [ADDR_W-1:0] m_address_q, m_address_d;
  logic [DATA_W-1:0] m_data_in_q, m_data_in_d;
  logic [1:0]        m_size_q, m_size_d;
  logic              i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              gnt_i, gnt_d, conflict;

  always_comb begin
    state_d     = state_q;
    owner_i_d   = owner_i_q;
    starve_d    = starve_q;
    m_enable_d  = 1'b0;
    m_rw_d      = m_rw_q;
    m_address_d = m_address_q;
    m_data_in_d = m_data_in_q;
    m_size_d    = m_size_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    gnt_i       = 1'b0;
    gnt_d       = 1'b0;
    conflict    = 1'b0;
    case (state_q)
      IDLE: begin
        m_rw_d   = 1'b1;
        conflict = i_req & d_req;
        // D wins ties unless I has already lost STARVE_LIMIT times in a row
        if (i_req && (!d_req || starve_q == LIMIT)) begin
          gnt_i       = 1'b1;
          owner_i_d   = 1'b1;
          starve_d    = '0;
          m_address_d = i_addr;
          m_size_d    = i_size;
          m_rw_d      = 1'b1;
        end else if (d_req) begin
          gnt_d       = 1'b1;
          owner_i_d   = 1'b0;
          if (i_req && starve_q != LIMIT) starve_d = starve_q + SW'(1);
          m_address_d = d_addr;
          m_size_d    = d_size;
          m_data_in_d = d_wdata;
          m_rw_d      = ~d_we;
        end
        if (gnt_i || gnt_d) begin
          m_enable_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (!m_busy) begin
          // rdata and ack register on the same edge that enters RESP
          if (owner_i_q) begin
            i_rdata_d = m_data_out;
            i_ack_d   = 1'b1;
          end else begin
            if (m_rw_q) d_rdata_d = m_data_out;
            d_ack_d = 1'b1;
          end
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_i_q   <= 1'b0;
      starve_q    <= '0;
      m_enable_q  <= 1'b0;
      m_rw_q      <= 1'b0;
      m_address_q <= '0;
      m_data_in_q <= '0;
      m_size_q    <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_i_q   <= owner_i_d;
      starve_q    <= starve_d;
      m_enable_q  <= m_enable_d;
      m_rw_q      <= m_rw_d;
      m_address_q <= m_address_d;
      m_data_in_q <= m_data_in_d;
      m_size_q    <= m_size_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign m_enable      = m_enable_q;
  assign m_rw          = m_rw_q;
  assign m_address     = m_address_q;
  assign m_data_in     = m_data_in_q;
  assign m_access_size = m_size_q;
  assign i_ack         = i_ack_q;
  assign d_ack         = d_ack_q;
  assign i_rdata       = i_rdata_q;
  assign d_rdata       = d_rdata_q;
  assign i_stall       = i_req & ~i_ack_q;
  assign d_stall       = d_req & ~d_ack_q;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_i_q, stat_i_d, stat_d_q, stat_d_d, stat_c_q, stat_c_d;

  always_comb begin
    stat_i_d = stat_i_q + {31'd0, gnt_i};
    stat_d_d = stat_d_q + {31'd0, gnt_d};
    stat_c_d = stat_c_q + {31'd0, conflict};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_i_q <= '0;
      stat_d_q <= '0;
      stat_c_q <= '0;
    end else begin
      stat_i_q <= stat_i_d;
      stat_d_q <= stat_d_d;
      stat_c_q <= stat_c_d;
    end
  end

  assign stat_i_grants  = stat_i_q;
  assign stat_d_grants  = stat_d_q;
  assign stat_conflicts = stat_c_q;
`else
  assign stat_i_grants  = 32'd0;
  assign stat_d_grants  = 32'd0;
  assign stat_conflicts = 32'd0;
`endif

endmodule
